// File: rtl/sram_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sram_access_arbiter
// Brief    : Shares one asynchronous SRAM port between a recorder (write) and
//            a player (read) with round-robin arbitration and end tracking.
// Revision : 1.0
// ============================================================================
module sram_access_arbiter #(
    parameter int unsigned ADDR_W = 20,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned RD_LAT = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_wr_req,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic              o_wr_ack,
    input  logic              i_rd_req,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic              o_rd_valid,
    output logic [DATA_W-1:0] o_rd_data,
    input  logic              i_clr_end,
    output logic [ADDR_W-1:0] o_rec_end,
    output logic              o_busy,
    output logic [ADDR_W-1:0] o_SRAM_ADDR,
    inout  wire  [DATA_W-1:0] io_SRAM_DQ,
    output logic              o_SRAM_WE_N,
    output logic              o_SRAM_CE_N,
    output logic              o_SRAM_OE_N,
    output logic              o_SRAM_LB_N,
    output logic              o_SRAM_UB_N
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_WR      = 2'd1;
    localparam logic [1:0] S_WR_HOLD = 2'd2;
    localparam logic [1:0] S_RD      = 2'd3;

    localparam logic [2:0]        c_rd_last  = 3'(RD_LAT - 1);
    localparam logic [ADDR_W-1:0] c_addr_max = '1;

    logic [1:0]        r_state;
    logic [1:0]        w_next_state;
    logic              r_prio_wr;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wr_data;
    logic [2:0]        r_cnt;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_rd_valid;
    logic [ADDR_W-1:0] r_rec_end;

    logic              w_grant_wr;
    logic              w_grant_rd;
    logic              w_rd_done;
    logic              w_we_n;
    logic              w_ce_n;
    logic              w_oe_n;
    logic              w_dq_oe;
    logic              w_wr_ack;
    logic [ADDR_W-1:0] w_end_base;
    logic [ADDR_W-1:0] w_end_cand;
    logic [ADDR_W-1:0] w_end_next;

    // Contention resolves to the pointer side; a lone request always wins.
    assign w_grant_wr = i_wr_req && (!i_rd_req || r_prio_wr);
    assign w_grant_rd = i_rd_req && (!i_wr_req || !r_prio_wr);
    assign w_rd_done  = (r_state == S_RD) && (r_cnt == c_rd_last);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_grant_wr) begin
                    w_next_state = S_WR;
                end else if (w_grant_rd) begin
                    w_next_state = S_RD;
                end
            end
            S_WR:      w_next_state = S_WR_HOLD;
            S_WR_HOLD: w_next_state = S_IDLE;
            S_RD: begin
                if (w_rd_done) begin
                    w_next_state = S_IDLE;
                end
            end
            default:   w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        w_we_n   = 1'b1;
        w_ce_n   = 1'b1;
        w_oe_n   = 1'b1;
        w_dq_oe  = 1'b0;
        w_wr_ack = 1'b0;
        case (r_state)
            S_WR: begin
                w_ce_n  = 1'b0;
                w_we_n  = 1'b0;
                w_dq_oe = 1'b1;
            end
            S_WR_HOLD: begin
                w_ce_n   = 1'b0;
                w_dq_oe  = 1'b1;
                w_wr_ack = 1'b1;
            end
            S_RD: begin
                w_ce_n = 1'b0;
                w_oe_n = 1'b0;
            end
            default: begin
                w_ce_n = 1'b1;
            end
        endcase
    end

    // A clear coinciding with a commit is applied first, so the commit still lands.
    assign w_end_base = i_clr_end ? '0 : r_rec_end;
    assign w_end_cand = (r_addr == c_addr_max) ? c_addr_max : r_addr + 1'b1;
    assign w_end_next = (w_end_cand > w_end_base) ? w_end_cand : w_end_base;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_prio_wr  <= 1'b1;
            r_addr     <= '0;
            r_wr_data  <= '0;
            r_cnt      <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_rec_end  <= '0;
        end else begin
            r_rd_valid <= w_rd_done;
            if (r_state == S_IDLE) begin
                if (w_grant_wr) begin
                    r_addr    <= i_wr_addr;
                    r_wr_data <= i_wr_data;
                    r_prio_wr <= 1'b0;
                end else if (w_grant_rd) begin
                    r_addr    <= i_rd_addr;
                    r_cnt     <= '0;
                    r_prio_wr <= 1'b1;
                end
            end
            if (r_state == S_RD) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_rd_done) begin
                r_rd_data <= io_SRAM_DQ;
            end
            if (w_wr_ack) begin
                r_rec_end <= w_end_next;
            end else if (i_clr_end) begin
                r_rec_end <= '0;
            end
        end
    end

    assign io_SRAM_DQ  = w_dq_oe ? r_wr_data : {DATA_W{1'bz}};
    assign o_SRAM_ADDR = r_addr;
    assign o_SRAM_WE_N = w_we_n;
    assign o_SRAM_CE_N = w_ce_n;
    assign o_SRAM_OE_N = w_oe_n;
    assign o_SRAM_LB_N = 1'b0;
    assign o_SRAM_UB_N = 1'b0;
    assign o_wr_ack    = w_wr_ack;
    assign o_rd_valid  = r_rd_valid;
    assign o_rd_data   = r_rd_data;
    assign o_rec_end   = r_rec_end;
    assign o_busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: doc/sram_access_arbiter.md
Name: sram_access_arbiter

Overview:
- Owns the single external SRAM port and shares it between two requesters: the recorder (write requester) and the DSP/player (read requester).
- Replaces the top-level mux that statically steers SRAM by FSM state. Both paths can be live at the same time, for example during monitor-while-record.
- Sequences the SRAM control strobes, bounds read latency, and tracks the recorded end address so the player knows where to stop.

Parameters:
ADDR_W, 20, SRAM word-address width
DATA_W, 16, SRAM data width
RD_LAT, 2, cycles OE_N is held low before DQ is captured (legal range 1..7)

Ports:
i_clk  in  1  system clock (BCLK domain)
i_rst  in  1  asynchronous reset, active-high
i_wr_req  in  1  recorder write request (level)
i_wr_addr  in  ADDR_W  write word address
i_wr_data  in  DATA_W  write data
o_wr_ack  out  1  one-cycle pulse: write committed to SRAM
i_rd_req  in  1  player read request (level)
i_rd_addr  in  ADDR_W  read word address
o_rd_valid  out  1  one-cycle pulse: o_rd_data valid
o_rd_data  out  DATA_W  captured read data, held until the next read
i_clr_end  in  1  clears o_rec_end (pulse at record start)
o_rec_end  out  ADDR_W  highest committed write address +1, saturating
o_busy  out  1  state != S_IDLE
o_SRAM_ADDR  out  ADDR_W  SRAM address
io_SRAM_DQ  inout  DATA_W  SRAM data; driven only in the write states, otherwise high-Z
o_SRAM_WE_N, o_SRAM_CE_N, o_SRAM_OE_N  out  1 each  SRAM strobes
o_SRAM_LB_N, o_SRAM_UB_N  out  1 each  constant 0

Behaviour:
- Clocking and reset: one clock, i_clk. i_rst is asynchronous and active-high.
- Reset values, applied immediately including mid-transaction:
  - state S_IDLE
  - WE_N=1, OE_N=1, CE_N=1
  - DQ high-Z
  - o_SRAM_ADDR=0, o_rd_data=0, o_rec_end=0
  - o_wr_ack=0, o_rd_valid=0, o_busy=0
  - priority pointer = write
- States: S_IDLE, S_WR, S_WR_HOLD, S_RD.
- S_IDLE arbitration, evaluated every cycle:
  - Only one request high: grant it.
  - Both high: grant the side named by the priority pointer. The pointer then flips to the other side, giving round-robin.
  - A single-sided grant sets the pointer to the other side.
  - At grant, addr and data are latched internally; the requester does not need to hold them afterwards.
- Write sequence (request seen in S_IDLE at cycle t):
  - t+1, S_WR: ADDR=latched addr, DQ driven, CE_N=0, WE_N=0.
  - t+2, S_WR_HOLD: WE_N=1, DQ and ADDR still driven, CE_N=0, o_wr_ack=1.
  - t+3: S_IDLE; a new grant is possible in this cycle.
- Read sequence (request seen in S_IDLE at cycle t):
  - t+1 through t+RD_LAT, S_RD: ADDR=latched addr, CE_N=0, OE_N=0, DQ high-Z; a cycle counter runs.
  - On the last S_RD cycle the DQ value is registered into o_rd_data.
  - t+RD_LAT+1: o_rd_valid=1, state S_IDLE.
- Request-level rule: the requester must deassert its request in the cycle its ack/valid is seen. A request still high in that cycle is treated as a new request.
- o_rec_end update on each o_wr_ack: o_rec_end <= max(o_rec_end, addr+1). The value saturates at 2^ADDR_W-1 and does not wrap.
- i_clr_end: sets o_rec_end to 0 next cycle. If a write commits in the same cycle, the clear is applied first, then the commit, so the result is addr+1.
- A request deasserted after grant does not cancel the transaction; the access completes.
- No write/read overlap ever: WE_N=0 and OE_N=0 are never low together, and DQ is never driven while OE_N=0.

Test Plan:
1. Reset, then single write addr=0x00010, data=0xBEEF:
   - WE_N=0 at cycle 1 after request; o_wr_ack at cycle 2.
   - o_rec_end=0x00011.
   - A subsequent read of 0x00010 returns o_rd_valid with 0xBEEF exactly RD_LAT+1 cycles after request.
2. i_wr_req and i_rd_req rise in the same cycle, both held high, with new addresses each grant:
   - Grants alternate W,R,W,R.
   - No two consecutive grants go to the same side; strobes never overlap.
3. Write to addr=0xFFFFF:
   - o_rec_end=0xFFFFF (saturated, not 0).
   - i_clr_end together with a commit to addr 0x5 -> o_rec_end=0x6.
4. Assert i_rst during S_WR:
   - Same-cycle WE_N=1, CE_N=1, DQ=Z, o_busy=0.
   - No o_wr_ack pulse follows.
5. RD_LAT=1 and RD_LAT=7 builds:
   - o_rd_valid exactly 2 and 8 cycles after request respectively.
   - OE_N low for exactly RD_LAT cycles.
6. Requester drops i_rd_req one cycle after grant:
   - Read still completes with an o_rd_valid pulse.
   - Arbiter returns to S_IDLE and issues no extra grant.
